// File: rtl/delayed_mem_slave_if.sv
// Request/response bus of the delayed scratch memory, plus the handshake
// with the random-delay generator that sits beside it.
interface delayed_mem_slave_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  // response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // delay generator handshake
  logic        delay_req;
  logic        delay_done;

  // memory side
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  resp_ready, delay_done,
    output req_ready, resp_valid, resp_rdata, resp_err, delay_req
  );

  // core side (LSU/IFU) together with the delay generator
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output resp_ready, delay_done,
    input  req_ready, resp_valid, resp_rdata, resp_err, delay_req
  );
endinterface

// File: rtl/delayed_mem_slave.sv
// Word-addressed scratch memory with externally generated access latency.
// An accepted request fires a one-cycle delay_req and is held in WAIT until
// the delay generator answers with delay_done, or until the timeout expires.
// Storage is four byte-lane arrays with a registered read, so each lane maps
// onto block RAM; memory contents are never touched by reset.
module delayed_mem_slave #(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 32
) (
  input logic                clk,
  input logic                reset,
  delayed_mem_slave_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state_reg;

  // latched request
  logic             wen_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wmask_reg;

  // cycles spent in WAIT for the current access
  logic [CNT_W-1:0] cnt_reg;

  // registered outputs
  logic             req_ready_reg;
  logic             resp_valid_reg;
  logic             resp_err_reg;
  logic             delay_req_reg;
  // high while the response carries read data from the memory
  logic             rdata_ok_reg;

  logic             addr_err;
  logic             complete;
  logic             mem_wr;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;

  // Misaligned or beyond the last word; compared on the full word address so
  // high address bits that alias into the index are still rejected.
  assign addr_err = (addr_reg[1:0] != 2'b00) || ((addr_reg >> 2) >= 32'(DEPTH));
  assign idx      = addr_reg[IDX_W+1:2];

  // delay_done only means something while an access is waiting; a
  // coincident timeout loses to it because complete is checked first.
  assign complete = (state_reg == WAIT) && bus.delay_done;
  // The write commits on the completing edge; a reset drops it because the
  // state is forced out of WAIT.
  assign mem_wr   = complete && wen_reg && !addr_err;

  // Request/response FSM with all handshake outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wen_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
      cnt_reg        <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      delay_req_reg  <= 1'b0;
      rdata_ok_reg   <= 1'b0;
    end else begin
      // delay_req is a single-cycle pulse: only the acceptance edge raises it
      delay_req_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            wen_reg       <= bus.req_wen;
            addr_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            wmask_reg     <= bus.req_wmask;
            cnt_reg       <= '0;
            delay_req_reg <= 1'b1;
            req_ready_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.delay_done) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= addr_err;
            rdata_ok_reg   <= !wen_reg && !addr_err;
            state_reg      <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
            rdata_ok_reg   <= 1'b0;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            rdata_ok_reg   <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // One RAM per byte lane: masked write, read-before-write on the completing
  // edge, and the read register holds its value through RESP.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd;

      // Lane write and registered read
      always_ff @(posedge clk) begin
        if (mem_wr && wmask_reg[gi]) begin
          lane_mem[idx] <= wdata_reg[8*gi +: 8];
        end
        if (complete) begin
          lane_rd <= lane_mem[idx];
        end
      end

      assign rd_word[8*gi +: 8] = lane_rd;
    end
  endgenerate

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.delay_req  = delay_req_reg;
  // Writes, errors and idle periods all present zero read data
  assign bus.resp_rdata = rdata_ok_reg ? rd_word : 32'h0;

endmodule

// File: tb/tb_delayed_mem_slave.sv
// Self-checking bench for delayed_mem_slave: directed scenarios followed by
// randomised accesses, all checked against a word-array model of the memory
// and the latency rules (done + 1 cycle, or TIMEOUT + 1 cycles on timeout).
module tb_delayed_mem_slave;

  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 32;
  localparam int NEVER   = 1000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  delayed_mem_slave_if bus ();

  delayed_mem_slave #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference contents, one 32-bit word per entry
  logic [31:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_delay_req"}, bus.delay_req, 0);
  endtask

  // One complete access. delay = cycles after the delay_req cycle at which
  // delay_done is pulsed (NEVER = no pulse); hold = cycles of backpressure
  // in RESP, during which req_valid is held and a spurious delay_done fires.
  task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int delay, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          lat;
    bit          seen;
    int          w;

    exp_err   = (addr % 4 != 0) || (addr / 4 >= DEPTH) || (delay > TIMEOUT - 1);
    exp_lat   = (delay <= TIMEOUT - 1) ? delay + 1 : TIMEOUT;
    w         = int'(addr / 4);
    exp_rdata = (!exp_err && !wen) ? model[w] : 32'h0;
    if (!exp_err && wen) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
      end
    end

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;

    // first cycle after acceptance: the delay_req cycle
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("delay_req_pulse", bus.delay_req, 1);
    chk("req_ready_wait", bus.req_ready, 0);

    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c <= TIMEOUT + 3; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      if (c > 0) chk("delay_req_single", bus.delay_req, 0);
      bus.delay_done = (c == delay);
    end
    bus.delay_done = 1'b0;

    chk("resp_seen", seen, 1);
    chk("resp_latency", lat, exp_lat);
    chk("resp_err", bus.resp_err, exp_err);
    chk("resp_rdata", bus.resp_rdata, exp_rdata);

    for (int h = 0; h < hold; h++) begin
      bus.req_valid  = 1'b1;
      bus.delay_done = (h == 1);
      @(negedge clk);
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_err", bus.resp_err, exp_err);
      chk("hold_rdata", bus.resp_rdata, exp_rdata);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid  = 1'b0;
    bus.delay_done = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_dropped", bus.resp_valid, 0);
    chk("req_ready_back", bus.req_ready, 1);

    $display("%s addr=%h wdata=%h mask=%h delay=%0d hold=%0d -> err=%0b rdata=%h latency=%0d",
             wen ? "WR" : "RD", addr, wdata, wmask, delay, hold, exp_err, exp_rdata, lat);
  endtask

  // delay_done while idle must leave the block idle
  task automatic idle_pulse();
    bus.delay_done = 1'b1;
    @(negedge clk);
    bus.delay_done = 1'b0;
    @(negedge clk);
    check_idle("idle_pulse");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] keep;
    int          r;
    int          d;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wmask  = 4'h0;
    bus.resp_ready = 1'b0;
    bus.delay_done = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_delay_req", bus.delay_req, 0);
    reset = 1'b0;

    // give every word a known value
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 32'(i * 4), $urandom, 4'hF, $urandom_range(0, 3), 0);
    end

    // basic write then read
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 3, 0);
    // byte masking: expected read 0xDE22BE44
    access(1'b1, 32'h10, 32'h11223344, 4'b0101, 1, 0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
    // zero mask write leaves the word alone
    access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 2, 0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 2, 0);
    // address errors
    access(1'b0, 32'h02, 32'h0, 4'h0, 2, 0);
    access(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 2, 0);
    access(1'b0, 32'h00, 32'h0, 4'h0, 2, 0);
    // timeout, and delay_done on the final WAIT cycle
    access(1'b0, 32'h14, 32'h0, 4'h0, NEVER, 0);
    access(1'b1, 32'h14, 32'h0BADC0DE, 4'hF, NEVER, 0);
    access(1'b0, 32'h14, 32'h0, 4'h0, TIMEOUT - 1, 0);
    access(1'b1, 32'h18, 32'h5A5A5A5A, 4'hF, TIMEOUT - 1, 0);
    // backpressure with spurious delay_done in RESP, then one in IDLE
    access(1'b0, 32'h18, 32'h0, 4'h0, 4, 5);
    idle_pulse();
    access(1'b0, 32'h10, 32'h0, 4'h0, 1, 0);

    // reset two cycles after a write is accepted
    keep = model[8];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = ~keep;
    bus.req_wmask = 4'hF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wait_rst_req_ready", bus.req_ready, 1);
    chk("wait_rst_resp_valid", bus.resp_valid, 0);
    chk("wait_rst_resp_rdata", bus.resp_rdata, 0);
    chk("wait_rst_resp_err", bus.resp_err, 0);
    chk("wait_rst_delay_req", bus.delay_req, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_pulse();
    $display("RST write to 00000020 abandoned in WAIT");
    access(1'b0, 32'h20, 32'h0, 4'h0, 2, 0);

    // randomised accesses
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      end else if (r == 1) begin
        a = 32'($urandom_range(DEPTH, 4000)) << 2;
      end else begin
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      end
      r = $urandom_range(0, 19);
      if (r == 0) d = NEVER;
      else if (r == 1) d = TIMEOUT - 1;
      else d = $urandom_range(0, 6);
      access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), d,
             $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delayed_mem_slave.md
# delayed_mem_slave

Word-addressed scratch memory behind a valid/ready request/response port. It adds a variable, externally generated latency to every access. On accepting a request it fires a one-cycle `delay_req` to the random-delay generator that sits beside it, then holds the access until that generator's one-cycle `delay_done` pulse arrives. The block is the consumer of that generator in the NPC memory path: the core's LSU/IFU issues requests and sees randomised memory latency.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, ≥2. `IDX_W = log2(DEPTH)`.
- `TIMEOUT`, 32: maximum number of WAIT cycles before an error response; ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; equals (state == IDLE).
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_wmask`  in  4  byte-lane write enables; bit i selects `wdata[8i+7:8i]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `resp_err`  out  1  access failed (bad address or timeout).
- `delay_req`  out  1  one-cycle pulse to the delay generator.
- `delay_done`  in  1  one-cycle completion pulse from the delay generator.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. When `req_valid` is high, the request is accepted. On acceptance:
  - latch wen, addr, wdata, wmask;
  - go to WAIT;
  - set `delay_req` to 1 for the next cycle only;
  - clear the timeout counter to 0.
- WAIT: the counter increments each cycle. `delay_done`=1 completes the access:
  - address error if `addr[1:0] != 0` or `addr[31:2] >= DEPTH`;
  - no error, write: memory word `addr[IDX_W+1:2]` is updated lane-by-lane per wmask; `resp_rdata`=0;
  - no error, read: `resp_rdata` = that word as it was before this cycle;
  - error: no memory write; `resp_rdata`=0; `resp_err`=1;
  - then go to RESP.
- WAIT timeout: `delay_done`=0 while counter == TIMEOUT-1 gives:
  - `resp_err`=1, `resp_rdata`=0, no write;
  - go to RESP.
  - If `delay_done` and the timeout coincide, `delay_done` wins.
- RESP: `resp_valid`=1. `resp_rdata` and `resp_err` are held stable. On `resp_ready`=1, go to IDLE.
- `delay_done` in IDLE or RESP is ignored; it has no effect on state or memory.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there.
- A `wmask` of 0 on a write is legal: no bytes change and the response is normal.
- Memory contents are not affected by reset.
- Reset mid-operation (any state) has these effects:
  - go to IDLE immediately;
  - any pending write is dropped;
  - no response is issued.

## Timing
- Reset values: `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `delay_req`=0, `req_ready`=1.
- Acceptance at edge T (IDLE, `req_valid`=1) gives `delay_req`=1 during cycle T+1 only, and state is WAIT from T+1.
- `delay_done` is sampled in every WAIT cycle, including the `delay_req` cycle.
- `delay_done` sampled at edge D gives `resp_valid`=1 from cycle D+1.
- Minimum latency from acceptance to `resp_valid` is 2 cycles.
- Timeout: with no `delay_done`, `resp_valid` rises TIMEOUT+1 cycles after acceptance.
- Response handshake at edge R gives `req_ready`=1 in cycle R+1. Back-to-back requests are therefore spaced by at least 3 cycles.
- `delay_req` is never high for two consecutive cycles. This guarantees the delay generator sees one request per access.

## Test plan
- Basic write then read:
  - write addr 0x10, data 0xDEADBEEF, mask 0xF, `delay_done` 3 cycles after `delay_req` gives a response with err=0, rdata=0;
  - read 0x10 gives rdata=0xDEADBEEF, err=0;
  - `resp_valid` rises exactly 1 cycle after `delay_done`.
- Byte masking:
  - after the word 0xDEADBEEF, write 0x11223344 with mask 0b0101;
  - a read returns 0xDE22BE44.
- Address errors:
  - read 0x02 (misaligned) gives err=1, rdata=0;
  - write to 0x100 (DEPTH=64) gives err=1;
  - a subsequent read of 0x00 shows the word unchanged.
- Timeout:
  - never pulse `delay_done`;
  - the response has err=1 exactly TIMEOUT+1 cycles after acceptance;
  - `delay_done` coincident with the final WAIT cycle gives err=0.
- Backpressure and spurious pulses:
  - hold `resp_ready`=0 for 5 cycles; rdata and err stay stable, and `req_ready` stays 0 while `req_valid` is held 1;
  - a `delay_done` pulsed in RESP and in IDLE has no effect.
- Reset in WAIT: assert `reset` two cycles after a write request is accepted. Required results:
  - all outputs return to their reset values immediately;
  - a later `delay_done` is ignored;
  - a read of that address shows no write occurred.
